// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : shares one byte-wide RAM port between instruction fetch and
//               the MEM stage, serialising every access into byte transfers.
// Optional feature macro: MEM_ARB_JUMP_CANCEL_EN (taken jump aborts a fetch).
// Rev 1.0
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              jump_enable,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_RD  = 2'd1,
    S_MEM_RD = 2'd2,
    S_MEM_WR = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [2:0]        r_q, r_d;
  logic [2:0]        n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic              jump_cancel;
  logic [2:0]        mem_n;

`ifdef MEM_ARB_JUMP_CANCEL_EN
  assign jump_cancel = jump_enable;
`else
  logic jump_unused;
  assign jump_unused = jump_enable;
  assign jump_cancel = 1'b0;
`endif

  assign mem_n = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    r_d         = r_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        k_d = 3'd0;
        r_d = 3'd0;
        // a done pulse in flight gives the requester one cycle to drop its request
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            state_d = mem_we ? S_MEM_WR : S_MEM_RD;
            base_d  = mem_addr;
            n_d     = mem_n;
            wdata_d = mem_wdata;
            buf_d   = 32'd0;
          end else if (if_req && !jump_cancel) begin
            state_d = S_IF_RD;
            base_d  = if_addr;
            n_d     = 3'd4;
            buf_d   = 32'd0;
          end
        end
      end

      S_IF_RD, S_MEM_RD: begin
        if (k_q < n_q) k_d = k_q + 3'd1;
        // ram_din carries the byte addressed one cycle earlier
        if (r_q < k_q) begin
          buf_d[{r_q[1:0], 3'b000} +: 8] = ram_din;
          r_d = r_q + 3'd1;
          if (r_q == n_q - 3'd1) begin
            state_d = S_IDLE;
            k_d     = 3'd0;
            r_d     = 3'd0;
            if (state_q == S_IF_RD) begin
              if_data_d = buf_d;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = buf_d;
              mem_done_d  = 1'b1;
            end
          end
        end
        if (state_q == S_IF_RD && jump_cancel) begin
          state_d   = S_IDLE;
          k_d       = 3'd0;
          r_d       = 3'd0;
          if_data_d = if_data_q;
          if_done_d = 1'b0;
        end
      end

      S_MEM_WR: begin
        k_d = k_q + 3'd1;
        if (k_q == n_q - 3'd1) begin
          state_d    = S_IDLE;
          k_d        = 3'd0;
          mem_done_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      k_q         <= 3'd0;
      r_q         <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      k_q         <= k_d;
      r_q         <= r_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_addr  = base_q + ADDR_W'(k_q);
  assign ram_wr    = (state_q == S_MEM_WR) && rdy_in;
  assign ram_dout  = wdata_q[{k_q[1:0], 3'b000} +: 8];

endmodule

`default_nettype wire
